// File: rtl/morse_receiver_pkg.sv
// Shared types and Morse timing constants for the Morse receive path.
package morse_receiver_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StMark,
      StSpace
   } rx_state_e;

   localparam int unsigned DOT_UNITS      = 1;
   localparam int unsigned DASH_UNITS     = 3;
   localparam int unsigned CHAR_GAP_UNITS = 3;
   localparam int unsigned WORD_GAP_UNITS = 7;
   localparam int unsigned CODE_WIDTH     = 20;
   localparam int unsigned LEN_WIDTH      = 5;

endpackage

// File: rtl/morse_receiver_if.sv
// Character handshake between the Morse receiver and its downstream consumer.
interface morse_receiver_if #(
   parameter int unsigned CodeWidth = morse_receiver_pkg::CODE_WIDTH
);
   import morse_receiver_pkg::*;

   logic [CodeWidth-1:0] code;
   logic [LEN_WIDTH-1:0] len;
   logic                 valid;
   logic                 ready;
   logic                 word;
   logic                 overflow;
   logic                 overrun;

   modport master (
      output code, len, valid, word, overflow, overrun,
      input  ready
   );

   modport slave (
      input  code, len, valid, word, overflow, overrun,
      output ready
   );

endinterface

// File: rtl/morse_receiver_key_conditioner.sv
// Two-flop synchronizer plus debounce for a raw button; emits the clean level and
// a one-cycle pulse aligned with each level change.
module key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key,
   output logic o_level,
   output logic o_edge
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]      sync_q, sync_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            edge_q, edge_d;

   always_comb begin
      sync_d  = {sync_q[0], i_key};
      cnt_d   = '0;
      level_d = level_q;
      edge_d  = 1'b0;
      // Count consecutive disagreeing samples; any agreeing sample restarts the count.
      if (sync_q[1] != level_q) begin
         if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q[1];
            edge_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         edge_q  <= edge_d;
      end
   end

   assign o_level = level_q;
   assign o_edge  = edge_q;

endmodule

// File: rtl/morse_receiver.sv
// Samples the debounced key once per Morse unit and rebuilds each character as a
// left-aligned on/off unit pattern, handed downstream over a valid/ready handshake.
module morse_receiver #(
   parameter int unsigned UNIT_CYCLES     = 6000000,
   parameter int unsigned DEBOUNCE_CYCLES = 120000,
   parameter int unsigned CODE_WIDTH      = morse_receiver_pkg::CODE_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_key,
   morse_receiver_if.master bus
);
   import morse_receiver_pkg::*;

   localparam int unsigned       PrescW    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [PrescW-1:0] PrescLast = PrescW'(UNIT_CYCLES - 1);
   localparam logic [PrescW-1:0] PrescMid  = PrescW'(UNIT_CYCLES / 2);
   localparam logic [5:0]        IdxStart  = 6'(CODE_WIDTH - 2);

   logic key_db, key_edge, strobe, start, complete;

   logic [PrescW-1:0]     presc_q, presc_d;
   rx_state_e             state_q, state_d;
   logic [CODE_WIDTH-1:0] pat_q, pat_d;
   logic [5:0]            idx_q, idx_d;
   logic [1:0]            zero_run_q, zero_run_d;
   logic [2:0]            gap_q, gap_d;
   logic [4:0]            len_q, len_d;
   logic                  arm_q, arm_d;
   logic [CODE_WIDTH-1:0] code_q, code_d;
   logic [4:0]            code_len_q, code_len_d;
   logic                  valid_q, valid_d;
   logic                  word_q, word_d;
   logic                  overflow_q, overflow_d;
   logic                  overrun_q, overrun_d;

   key_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_key  (i_key),
      .o_level(key_db),
      .o_edge (key_edge)
   );

   // Re-aligning to each key edge keeps the strobe centred in the sender's units.
   always_comb begin
      if (key_edge || presc_q == PrescLast) presc_d = '0;
      else                                  presc_d = presc_q + PrescW'(1);
      strobe = (presc_q == PrescMid) && !key_edge;
   end

   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      idx_d      = idx_q;
      zero_run_d = zero_run_q;
      gap_d      = gap_q;
      len_d      = len_q;
      arm_d      = arm_q;
      code_d     = code_q;
      code_len_d = code_len_q;
      valid_d    = valid_q;
      word_d     = 1'b0;
      overflow_d = overflow_q;
      overrun_d  = overrun_q;
      start      = 1'b0;
      complete   = 1'b0;

      if (valid_q && bus.ready) valid_d = 1'b0;

      if (strobe) begin
         unique case (state_q)
            StIdle: start = key_db;
            StMark: begin
               // idx wrapping negative means all CODE_WIDTH units are already used.
               if (idx_q[5]) begin
                  overflow_d = 1'b1;
                  arm_d      = 1'b0;
                  gap_d      = '0;
                  state_d    = StSpace;
               end else begin
                  pat_d[idx_q[4:0]] = key_db;
                  idx_d             = idx_q - 6'd1;
                  if (key_db) begin
                     zero_run_d = '0;
                     len_d      = 5'(CODE_WIDTH) - idx_q[4:0];
                  end else begin
                     zero_run_d = zero_run_q + 2'd1;
                     complete   = (zero_run_q == 2'(CHAR_GAP_UNITS - 1));
                  end
               end
            end
            StSpace: begin
               if (key_db) begin
                  start = 1'b1;
               end else if (gap_q == 3'(WORD_GAP_UNITS - 1)) begin
                  word_d  = arm_q;
                  state_d = StIdle;
               end else begin
                  gap_d = gap_q + 3'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      if (start) begin
         pat_d             = '0;
         pat_d[CODE_WIDTH-1] = 1'b1;
         idx_d             = IdxStart;
         zero_run_d        = '0;
         len_d             = 5'(DOT_UNITS);
         state_d           = StMark;
      end

      if (complete) begin
         state_d = StSpace;
         gap_d   = 3'(CHAR_GAP_UNITS);
         arm_d   = 1'b1;
         if (valid_q && !bus.ready) begin
            overrun_d = 1'b1;
         end else begin
            code_d     = pat_d;
            code_len_d = len_q;
            valid_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         presc_q    <= '0;
         state_q    <= StIdle;
         pat_q      <= '0;
         idx_q      <= '0;
         zero_run_q <= '0;
         gap_q      <= '0;
         len_q      <= '0;
         arm_q      <= 1'b0;
         code_q     <= '0;
         code_len_q <= '0;
         valid_q    <= 1'b0;
         word_q     <= 1'b0;
         overflow_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         state_q    <= state_d;
         pat_q      <= pat_d;
         idx_q      <= idx_d;
         zero_run_q <= zero_run_d;
         gap_q      <= gap_d;
         len_q      <= len_d;
         arm_q      <= arm_d;
         code_q     <= code_d;
         code_len_q <= code_len_d;
         valid_q    <= valid_d;
         word_q     <= word_d;
         overflow_q <= overflow_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.code     = code_q;
   assign bus.len      = code_len_q;
   assign bus.valid    = valid_q;
   assign bus.word     = word_q;
   assign bus.overflow = overflow_q;
   assign bus.overrun  = overrun_q;

endmodule

// File: doc/morse_receiver.md
Name: morse_receiver

Overview:
- Receive side of the Morse link; the counterpart of the LED blinker.
- Samples a raw key/button input once per Morse unit and rebuilds each character as a 20-bit, left-aligned on/off unit pattern, in the same format the blinker consumes (bit 19 = first unit, 1 = key down).
- Presents each completed character to downstream logic through a valid/ready handshake and flags word gaps.
- Sits between the board key pin and the character decode/loopback logic.

Parameters:
- UNIT_CYCLES, 6000000, i_clk cycles per Morse unit (0.5 s at 12 MHz).
- DEBOUNCE_CYCLES, 120000, cycles the synchronized key must stay stable before the debounced level changes.
- CODE_WIDTH, 20, captured pattern width.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_key  in  1  raw key level, asynchronous, 1 = pressed
- i_ready  in  1  consumer accepts o_code this cycle
- o_code  out  20  captured unit pattern, left-aligned, zero-filled
- o_len  out  5  units from the first mark through the last mark (1..20)
- o_valid  out  1  o_code/o_len hold a character
- o_word  out  1  one-cycle pulse on a 7-unit gap
- o_overflow  out  1  sticky; set when a character exceeds 20 units
- o_overrun  out  1  sticky; set when a character is dropped because o_valid was still high

Behaviour:
- Reset: asynchronous on i_rst_n low. All outputs are 0. The state machine goes to IDLE and all counters clear.
- Input conditioning:
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level (key_db) changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
- Unit timing:
  - The prescaler counts 0..UNIT_CYCLES-1 and wraps.
  - It restarts at 0 on every key_db edge.
  - A sample strobe fires when the prescaler equals UNIT_CYCLES/2 (integer division), i.e. mid-unit.
  - Each strobe samples key_db as one unit bit.
- FSM:
  - IDLE:
    - A strobe with key_db=1 writes bit 19, sets idx=18, zero_run=0 and goes to MARK.
    - A strobe with key_db=0 does nothing.
  - MARK:
    - Each strobe writes the sample at idx and decrements idx.
    - Sample 1: zero_run=0 and len = 20-idx_before_write.
    - Sample 0: zero_run increments.
    - zero_run reaching 3 means the character is complete: present or drop it (see Output), then go to SPACE with gap=3.
    - Writing with idx already exhausted (a 21st unit) is overflow: set o_overflow, discard the pattern, go to SPACE with gap=0.
  - SPACE:
    - Strobe with 0: gap increments. When gap reaches 7, pulse o_word for one cycle (only if the preceding character was presented or dropped, not after overflow) and go to IDLE.
    - Strobe with 1: start a new character exactly as from IDLE.
- Output handshake:
  - On completion with o_valid=0, load o_code (bits below the last mark are 0, trailing gap zeros included) and o_len, and set o_valid.
  - On completion with o_valid=1, drop the new character and set o_overrun.
  - o_valid clears in the cycle after i_ready is sampled high while o_valid=1.
  - o_code and o_len are stable while o_valid=1.
  - If completion and acceptance fall in the same cycle, the new character loads and o_valid stays 1.
- Simultaneous events: a key_db edge on the same cycle as a strobe restarts the prescaler, and that strobe is suppressed.
- Reset mid-character drops the partial pattern; the sticky flags clear only on reset.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, MARK, SPACE)
  - constants DOT_UNITS=1, DASH_UNITS=3, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7, CODE_WIDTH=20
- Sub-module key_conditioner: synchronizer, debounce and edge output. It is reusable for other buttons.
- The prescaler/strobe and the FSM live in morse_receiver.

Test Plan (UNIT_CYCLES=8, DEBOUNCE_CYCLES=2):
- Dot (1 unit on) then 3 units off -> o_valid=1, o_code=20'h80000, o_len=1; o_valid holds until i_ready, then clears the next cycle.
- "A" (dot, gap, dash: units 1 0 1 1 1) then 3 off -> o_code=20'hB8000, o_len=5.
- "E", then 7 units off -> one character accepted, then exactly one o_word pulse; the FSM returns to IDLE.
- Two characters back to back with i_ready held 0 -> the first stays on o_code, the second is dropped and o_overrun=1.
- Key held 21 units -> o_overflow=1, o_valid stays 0, no o_word afterwards.
- Key glitch of 1 cycle -> ignored. Reset asserted mid-dash -> all outputs 0; a fresh dot afterwards decodes as 20'h80000.
